// File: rtl/fpm_pkg.sv
// rtl/fpm_pkg.sv - shared constants, stage-1 bundle and operand classification for the FP multiplier
package fpm_pkg;

  localparam int EXP_W   = 10;
  localparam int MANT_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;
  localparam int PROD_W  = 2 * (MANT_W + 1);

  // Stage-1 register bundle: normalised but not yet rounded.
  // e is the signed biased exponent, one bit wider than exp_sum.
  typedef struct packed {
    logic              sign;
    logic [EXP_W:0]    e;
    logic [MANT_W-1:0] m;
    logic              g;
    logic              s;
    logic              nan;
    logic              inf;
    logic              zer;
  } fpm_s1_t;

  // Operand class flags to result class {nan, inf, zer}; at most one bit set.
  function automatic logic [2:0] classify(input logic a_nan, input logic a_inf, input logic a_zer,
                                          input logic b_nan, input logic b_inf, input logic b_zer);
    logic nan_c, inf_c, zer_c;
    nan_c = a_nan | b_nan | (a_inf & b_zer) | (a_zer & b_inf);
    inf_c = (a_inf | b_inf) & ~nan_c;
    zer_c = (a_zer | b_zer) & ~nan_c & ~inf_c;
    return {nan_c, inf_c, zer_c};
  endfunction

endpackage

// File: rtl/fpm_round_rne.sv
// rtl/fpm_round_rne.sv - round-to-nearest-even with exponent range detection
module fpm_round_rne
  import fpm_pkg::*;
(
  input  logic [MANT_W-1:0] m,
  input  logic              g,
  input  logic              s,
  input  logic [EXP_W:0]    e,
  output logic [MANT_W-1:0] mantissa,
  output logic [7:0]        exponent,
  output logic              ovf,
  output logic              unf
);

  localparam logic signed [EXP_W:0] EMAX = (EXP_W+1)'(EXP_MAX);

  logic              rnd;
  logic [MANT_W:0]   m_r;
  logic signed [EXP_W:0] e_r;

  // Round up on guard when sticky is set or on an exact tie with an odd LSB;
  // a carry out of the mantissa means 1.111..1 became 10.0, so bump the exponent.
  always_comb begin
    rnd      = g & (s | m[0]);
    m_r      = {1'b0, m} + {{MANT_W{1'b0}}, rnd};
    mantissa = m_r[MANT_W] ? '0 : m_r[MANT_W-1:0];
    e_r      = $signed(e) + $signed({{EXP_W{1'b0}}, m_r[MANT_W]});
    exponent = e_r[7:0];
    ovf      = ~e_r[EXP_W] & (e_r >= EMAX);
    unf      = e_r[EXP_W] | (e_r == '0);
  end

endmodule

// File: rtl/fpm_norm_round.sv
// rtl/fpm_norm_round.sv - two-stage normalise/round stage of the FP multiplier
module fpm_norm_round
  import fpm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp_sum,
  input  logic [PROD_W-1:0]       mant_prod,
  input  logic                    a_nan,
  input  logic                    a_inf,
  input  logic                    a_zer,
  input  logic                    b_nan,
  input  logic                    b_inf,
  input  logic                    b_zer,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             Z,
  output logic                    nan,
  output logic                    inf,
  output logic                    zer
);

  logic              v1, v2;
  logic              adv1, adv2;
  fpm_s1_t           s1_d, s1_q;
  logic [MANT_W-1:0] r_mant;
  logic [7:0]        r_exp;
  logic              r_ovf, r_unf;
  logic              nan_d, inf_d, zer_d;
  logic [31:0]       z_d;

  // Backpressure chain: a stage may load when it is empty or its successor advances.
  always_comb begin
    adv2      = ~v2 | out_ready;
    adv1      = ~v1 | adv2;
    in_ready  = adv1;
    out_valid = v2;
  end

  // Stage 1: classify operands and normalise the product so the hidden 1 is dropped.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign;
    {s1_d.nan, s1_d.inf, s1_d.zer} = classify(a_nan, a_inf, a_zer, b_nan, b_inf, b_zer);
    if (mant_prod[PROD_W-1]) begin
      s1_d.m = mant_prod[46:24];
      s1_d.g = mant_prod[23];
      s1_d.s = |mant_prod[22:0];
      s1_d.e = {exp_sum[EXP_W-1], exp_sum} + (EXP_W+1)'(1);
    end else begin
      s1_d.m = mant_prod[45:23];
      s1_d.g = mant_prod[22];
      s1_d.s = |mant_prod[21:0];
      s1_d.e = {exp_sum[EXP_W-1], exp_sum};
    end
  end

  // Stage-1 register loads only when stage 1 advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      v1   <= in_valid;
      s1_q <= s1_d;
    end
  end

  fpm_round_rne u_round (
    .m        (s1_q.m),
    .g        (s1_q.g),
    .s        (s1_q.s),
    .e        (s1_q.e),
    .mantissa (r_mant),
    .exponent (r_exp),
    .ovf      (r_ovf),
    .unf      (r_unf)
  );

  // Stage 2: merge range faults into the class flags with nan > inf > zer priority.
  always_comb begin
    nan_d = s1_q.nan;
    inf_d = ~nan_d & (s1_q.inf | r_ovf);
    zer_d = ~nan_d & ~inf_d & (s1_q.zer | r_unf);
    z_d   = {s1_q.sign, r_exp, r_mant};
  end

  // Output register holds steady while the downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      Z   <= '0;
      nan <= 1'b0;
      inf <= 1'b0;
      zer <= 1'b0;
    end else if (adv2) begin
      v2  <= v1;
      Z   <= z_d;
      nan <= nan_d;
      inf <= inf_d;
      zer <= zer_d;
    end
  end

endmodule

// File: tb/tb_fpm_norm_round.sv
// tb/tb_fpm_norm_round.sv - table-driven checks of fpm_norm_round
module tb_fpm_norm_round;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              sign;
  logic signed [9:0] exp_sum;
  logic [47:0]       mant_prod;
  logic              a_nan, a_inf, a_zer, b_nan, b_inf, b_zer;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Z;
  logic              nan, inf, zer;

  int total = 0;
  int bad   = 0;

  fpm_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp_sum   (exp_sum),
    .mant_prod (mant_prod),
    .a_nan     (a_nan),
    .a_inf     (a_inf),
    .a_zer     (a_zer),
    .b_nan     (b_nan),
    .b_inf     (b_inf),
    .b_zer     (b_zer),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .nan       (nan),
    .inf       (inf),
    .zer       (zer)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [9:0]  es;
    logic [47:0] mp;
    logic [5:0]  cls;  // {a_nan, a_inf, a_zer, b_nan, b_inf, b_zer}
    logic [31:0] z;
    logic [2:0]  fl;   // {nan, inf, zer}
  } vec_t;

  vec_t vecs[$];
  logic [31:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    sign      = v.sgn;
    exp_sum   = v.es;
    mant_prod = v.mp;
    {a_nan, a_inf, a_zer, b_nan, b_inf, b_zer} = v.cls;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    sign      = 1'b0;
    exp_sum   = '0;
    mant_prod = '0;
    {a_nan, a_inf, a_zer, b_nan, b_inf, b_zer} = '0;
  endtask

  task automatic check_out(input string name, input vec_t v);
    logic [31:0] mask;
    mask = (v.fl != 3'b000) ? 32'h8000_0000 : 32'hFFFF_FFFF;
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_z"}, Z & mask, v.z & mask);
    check({name, "_flags"}, {29'b0, nan, inf, zer}, {29'b0, v.fl});
  endtask

  initial begin
    int n;
    int acc;
    int cyc;
    int stale;

    vecs.push_back('{1'b0, 10'd127, 48'h9000_0000_0000, 6'b000000, 32'h4010_0000, 3'b000});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0040_0000, 6'b000000, 32'h3F80_0000, 3'b000});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_00C0_0000, 6'b000000, 32'h3F80_0002, 3'b000});
    vecs.push_back('{1'b0, 10'd127, 48'h7FFF_FFC0_0000, 6'b000000, 32'h4000_0000, 3'b000});
    vecs.push_back('{1'b0, 10'd254, 48'h8000_0000_0000, 6'b000000, 32'h0000_0000, 3'b010});
    vecs.push_back('{1'b0, 10'd0,   48'h4000_0000_0000, 6'b000000, 32'h0000_0000, 3'b001});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0000_0000, 6'b010001, 32'h0000_0000, 3'b100});
    vecs.push_back('{1'b1, 10'd127, 48'h4000_0000_0000, 6'b000000, 32'hBF80_0000, 3'b000});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0040_0001, 6'b000000, 32'h3F80_0001, 3'b000});
    vecs.push_back('{1'b1, 10'd127, 48'h4000_0000_0000, 6'b001000, 32'h8000_0000, 3'b001});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0000_0000, 6'b000010, 32'h0000_0000, 3'b010});
    vecs.push_back('{1'b1, 10'd127, 48'h4000_0000_0000, 6'b100000, 32'h8000_0000, 3'b100});
    vecs.push_back('{1'b0, 10'd254, 48'h4000_0000_0000, 6'b000000, 32'h7F00_0000, 3'b000});
    vecs.push_back('{1'b0, 10'd1,   48'h4000_0000_0000, 6'b000000, 32'h0080_0000, 3'b000});
    vecs.push_back('{1'b0, 10'h381, 48'hC000_0000_0000, 6'b000000, 32'h0000_0000, 3'b001});
    vecs.push_back('{1'b0, 10'd254, 48'h7FFF_FFC0_0000, 6'b000000, 32'h0000_0000, 3'b010});
    vecs.push_back('{1'b0, 10'd383, 48'h8000_0000_0000, 6'b000000, 32'h0000_0000, 3'b010});
    vecs.push_back('{1'b0, 10'd127, 48'h4000_0000_0000, 6'b001010, 32'h0000_0000, 3'b100});

    // Reset state
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_z", Z, 32'd0);
    check("rst_flags", {29'b0, nan, inf, zer}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // Streaming table: one input per cycle, each result two cycles later
    n = vecs.size();
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      #1;
      if (c >= 2) check_out($sformatf("v%0d", c - 2), vecs[c - 2]);
      else        check($sformatf("lat%0d_valid", c), {31'b0, out_valid}, 32'd0);
      check($sformatf("c%0d_in_ready", c), {31'b0, in_ready}, 32'd1);
      if (c < n) drive(vecs[c]);
      else       idle();
    end
    @(negedge clk);
    check("drain_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: out_ready low for three cycles while four inputs are offered
    acc = 0;
    cyc = 0;
    while (got.size() < 4 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      if (acc < 4) drive(vecs[acc]);
      else         idle();
      #1;
      if (cyc == 2) check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      if (cyc == 3) check("bp_in_ready_rise", {31'b0, in_ready}, 32'd1);
      if (out_valid && out_ready) got.push_back(Z);
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    @(negedge clk);
    idle();
    check("bp_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("bp_order%0d", i), got[i], vecs[i].z);
    end
    repeat (2) @(negedge clk);
    check("bp_no_dup", {31'b0, out_valid}, 32'd0);

    // Reset while both stages are full
    out_ready = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    drive(vecs[1]);
    @(negedge clk);
    idle();
    #1;
    check("rs_pre_valid", {31'b0, out_valid}, 32'd1);
    check("rs_pre_in_ready", {31'b0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("rs_async_valid", {31'b0, out_valid}, 32'd0);
    check("rs_async_z", Z, 32'd0);
    check("rs_async_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rs_no_stale", stale, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
